inst_fetch: RTL and testbench

Fetch-side partner of the pc block.
- Consumes pc_o and jump from pc; returns the hold back-pressure pc expects.
- Issues in-order instruction-memory reads over a req/gnt/rvalid bus.
- Buffers returned words in a small queue and presents {inst, addr, valid} to decode.
- On jump, flushes the queue and discards in-flight responses.

---
 rtl/inst_fetch_pkg.sv | 13 +
 rtl/inst_fetch_fifo.sv | 80 ++++++++
 rtl/inst_fetch.sv | 150 +++++++++++++++
 tb/tb_inst_fetch.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared constants and FSM encoding for the instruction fetch unit.
package inst_fetch_pkg;

    localparam logic [31:0] INST_NOP      = 32'h0000_0013;
    localparam logic [31:0] INI_INST_ADDR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_START = 2'd0,
        IF_FETCH = 2'd1,
        IF_FLUSH = 2'd2
    } if_state_t;

endpackage

// File: rtl/inst_fetch_fifo.sv
// Circular fetch buffer: slots are allocated on grant, filled in order on response,
// and popped from the head. Pointers carry an extra MSB so count covers a full buffer.
module inst_fetch_fifo #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc,
    input  logic [ADDR_W-1:0] alloc_addr,
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              pop,
    input  logic              clear,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic [PTR_W:0]    count
);

    localparam logic [PTR_W-1:0] IDX_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   PTR_ONE = (PTR_W + 1)'(1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W:0]    fill_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic [PTR_W-1:0]  fill_idx;
    logic [PTR_W-1:0]  rd_idx;

    assign fill_idx   = fill_ptr[PTR_W-1:0];
    assign rd_idx     = rd_ptr[PTR_W-1:0];
    assign count      = fill_ptr - rd_ptr;
    assign head_valid = valid_q[rd_idx];
    assign head_addr  = addr_q[rd_idx];
    assign head_data  = data_q[rd_idx];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
            valid_q  <= '0;
        end else if (clear) begin
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
            valid_q  <= '0;
        end else begin
            if (alloc) begin
                wr_ptr <= wr_ptr + IDX_ONE;
            end
            if (fill) begin
                valid_q[fill_idx] <= 1'b1;
                fill_ptr          <= fill_ptr + PTR_ONE;
            end
            // A bypassed word fills and pops the same slot; the later clear wins.
            if (pop) begin
                valid_q[rd_idx] <= 1'b0;
                rd_ptr          <= rd_ptr + PTR_ONE;
            end
        end
    end

    // NOTE: payload storage has no reset; valid_q alone decides whether a slot is meaningful.
    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_q[wr_ptr] <= alloc_addr;
        end
        if (fill) begin
            data_q[fill_idx] <= fill_data;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: issues in-order reads for pc, queues responses for decode, flushes on jump.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              jump_i,
    output logic              hold_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              id_ready_i,
    output logic              inst_valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W:0]   DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

    if_state_t         state_q, state_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  discard_q, discard_d;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    occupancy;
    logic              head_valid;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              jump_act;
    logic              grant;
    logic              resp_live;
    logic              bypass;
    logic              pop;

    assign jump_act  = jump_i & (state_q != IF_START);
    assign occupancy = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign grant     = mem_req_o & mem_gnt_i;
    assign resp_live = mem_rvalid_i & (discard_q == '0) & ~jump_act;
    assign pop       = inst_valid_o & id_ready_i & ~jump_act;

`ifdef FETCH_BYPASS_EN
    assign bypass = resp_live & ~head_valid;
`else
    assign bypass = 1'b0;
`endif

    inst_fetch_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .alloc      (grant),
        .alloc_addr (pc_i),
        .fill       (resp_live),
        .fill_data  (mem_rdata_i),
        .pop        (pop),
        .clear      (jump_act),
        .head_valid (head_valid),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .count      (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IF_START;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        mem_req_o     = 1'b0;
        mem_addr_o    = pc_i;
        hold_o        = 1'b1;

        if (state_q == IF_FETCH && occupancy < DEPTH_LIM && !jump_i) begin
            mem_req_o = 1'b1;
        end
        hold_o = ~(mem_req_o & mem_gnt_i);

        if (grant) begin
            outstanding_d = outstanding_d + CNT_ONE;
        end
        if (mem_rvalid_i) begin
            outstanding_d = outstanding_d - CNT_ONE;
        end

        // A response arriving with the jump is already accounted for, so it is not discarded twice.
        if (jump_act) begin
            discard_d = outstanding_q - (mem_rvalid_i ? CNT_ONE : '0);
        end else if (mem_rvalid_i && discard_q != '0) begin
            discard_d = discard_q - CNT_ONE;
        end

        case (state_q)
            IF_START: state_d = IF_FETCH;
            IF_FETCH: begin
                if (jump_act && discard_d != '0) begin
                    state_d = IF_FLUSH;
                end
            end
            IF_FLUSH: begin
                if (discard_d == '0) begin
                    state_d = IF_FETCH;
                end
            end
            default: state_d = IF_START;
        endcase
    end

    always_comb begin
        inst_valid_o = 1'b0;
        inst_o       = DATA_W'(INST_NOP);
        inst_addr_o  = ADDR_W'(INI_INST_ADDR);
        if (head_valid) begin
            inst_valid_o = 1'b1;
            inst_o       = head_data;
            inst_addr_o  = head_addr;
        end else if (bypass) begin
            inst_valid_o = 1'b1;
            inst_o       = mem_rdata_i;
            inst_addr_o  = head_addr;
        end
    end

    rvalid_needs_outstanding: assert property (
        @(posedge clk) disable iff (!rst) mem_rvalid_i |-> (outstanding_q != '0)
    ) else $error("inst_fetch: rvalid with no outstanding request");

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: models pc and an in-order memory, checks hand-derived cycles.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        jump_i;
    logic        hold_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        id_ready_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;

    always #5 clk = ~clk;

    inst_fetch #(
        .FIFO_DEPTH (2),
        .ADDR_W     (32),
        .DATA_W     (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .jump_i       (jump_i),
        .hold_o       (hold_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .id_ready_i   (id_ready_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    bit          gnt_en, ready_en, resp_en, jump_en;
    logic [31:0] pc, jump_target;
    logic [31:0] mem_q[$];
    logic [31:0] pop_addr[$];
    logic [31:0] pop_word[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A00_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive inputs after the edge, settle, then update pc/memory/decode models.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        mem_gnt_i    = gnt_en;
        id_ready_i   = ready_en;
        jump_i       = jump_en;
        mem_rvalid_i = resp_en && (mem_q.size() != 0);
        mem_rdata_i  = mem_rvalid_i ? word_of(mem_q[0]) : 32'h0;
        pc_i         = pc;
        #4;
        if (inst_valid_o && id_ready_i && !jump_i) begin
            pop_addr.push_back(inst_addr_o);
            pop_word.push_back(inst_o);
        end
        if (mem_rvalid_i) void'(mem_q.pop_front());
        if (mem_req_o && mem_gnt_i) mem_q.push_back(mem_addr_o);
        if (jump_i) pc = jump_target;
        else if (!hold_o) pc = pc + 32'd4;
    endtask

    task automatic apply_reset();
        rst          = 1'b0;
        mem_q.delete();
        pop_addr.delete();
        pop_word.delete();
        pc           = 32'h0;
        jump_en      = 1'b0;
        pc_i         = 32'h0;
        jump_i       = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        mem_gnt_i    = gnt_en;
        id_ready_i   = ready_en;
        #1;
        check("rst_req",   mem_req_o,    32'd0);
        check("rst_hold",  hold_o,       32'd1);
        check("rst_valid", inst_valid_o, 32'd0);
        check("rst_inst",  inst_o,       32'h0000_0013);
        check("rst_addr",  inst_addr_o,  32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        #1;
        check("start_req",  mem_req_o, 32'd0);
        check("start_hold", hold_o,    32'd1);
    endtask

    initial begin
        gnt_en = 1'b1; ready_en = 1'b1; resp_en = 1'b1; jump_target = 32'h0;

        // Streaming with 1-cycle memory.
        apply_reset();
        step();
        check("s_c1_req", mem_req_o, 32'd1);
        check("s_c1_addr", mem_addr_o, 32'h0);
        check("s_c1_hold", hold_o, 32'd0);
        step();
        check("s_c2_req", mem_req_o, 32'd1);
        check("s_c2_addr", mem_addr_o, 32'h4);
        check("s_c2_valid", inst_valid_o, 32'd0);
        step();
        check("s_c3_valid", inst_valid_o, 32'd1);
        check("s_c3_iaddr", inst_addr_o, 32'h0);
        check("s_c3_inst", inst_o, word_of(32'h0));
        check("s_c3_req", mem_req_o, 32'd0);
        check("s_c3_hold", hold_o, 32'd1);
        repeat (4) step();
        check("s_npop", pop_addr.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < pop_addr.size()) begin
                check("s_pop_addr", pop_addr[i], 32'(4 * i));
                check("s_pop_word", pop_word[i], word_of(32'(4 * i)));
            end
        end

        // Grant stall: request held at 0x4 for three cycles.
        apply_reset();
        step();
        gnt_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("g_req", mem_req_o, 32'd1);
            check("g_hold", hold_o, 32'd1);
            check("g_addr", mem_addr_o, 32'h4);
        end
        gnt_en = 1'b1;
        step();
        check("g_grant_hold", hold_o, 32'd0);
        check("g_grant_addr", mem_addr_o, 32'h4);

        // Decode back-pressure fills the buffer.
        ready_en = 1'b0;
        apply_reset();
        step();
        step();
        check("b_c2_addr", mem_addr_o, 32'h4);
        check("b_c2_hold", hold_o, 32'd0);
        step();
        check("b_c3_req", mem_req_o, 32'd0);
        step();
        check("b_c4_req", mem_req_o, 32'd0);
        check("b_c4_hold", hold_o, 32'd1);
        check("b_c4_iaddr", inst_addr_o, 32'h0);
        step();
        check("b_c5_req", mem_req_o, 32'd0);
        check("b_c5_valid", inst_valid_o, 32'd1);
        ready_en = 1'b1;
        step();
        check("b_c6_iaddr", inst_addr_o, 32'h0);
        check("b_c6_req", mem_req_o, 32'd0);
        step();
        check("b_c7_iaddr", inst_addr_o, 32'h4);
        check("b_c7_req", mem_req_o, 32'd1);
        check("b_c7_addr", mem_addr_o, 32'h8);
        check("b_npop", pop_addr.size(), 32'd2);

        // Jump with two outstanding reads, then jump coinciding with a response.
        apply_reset();
        repeat (4) step();
        resp_en = 1'b0;
        step();
        check("j_c5_addr", mem_addr_o, 32'hC);
        check("j_c5_req", mem_req_o, 32'd1);
        jump_en = 1'b1; jump_target = 32'h100;
        step();
        check("j_c6_req", mem_req_o, 32'd0);
        jump_en = 1'b0; resp_en = 1'b1;
        pop_addr.delete(); pop_word.delete();
        step();
        check("j_c7_req", mem_req_o, 32'd0);
        check("j_c7_hold", hold_o, 32'd1);
        check("j_c7_valid", inst_valid_o, 32'd0);
        step();
        check("j_c8_req", mem_req_o, 32'd0);
        check("j_c8_valid", inst_valid_o, 32'd0);
        step();
        check("j_c9_req", mem_req_o, 32'd1);
        check("j_c9_addr", mem_addr_o, 32'h100);
        gnt_en = 1'b0;
        step();
        check("j_c10_addr", mem_addr_o, 32'h104);
        check("j_c10_hold", hold_o, 32'd1);
        gnt_en = 1'b1;
        step();
        check("j_c11_valid", inst_valid_o, 32'd1);
        check("j_c11_iaddr", inst_addr_o, 32'h100);
        check("j_c11_inst", inst_o, word_of(32'h100));
        check("j_c11_hold", hold_o, 32'd0);
        jump_en = 1'b1; jump_target = 32'h200;
        step();
        check("k_c12_req", mem_req_o, 32'd0);
        check("k_c12_valid", inst_valid_o, 32'd0);
        jump_en = 1'b0;
        step();
        check("k_c13_req", mem_req_o, 32'd1);
        check("k_c13_addr", mem_addr_o, 32'h200);
        check("k_c13_valid", inst_valid_o, 32'd0);
        step();
        check("k_c14_valid", inst_valid_o, 32'd0);
        step();
        check("k_c15_iaddr", inst_addr_o, 32'h200);
        check("k_npop", pop_addr.size(), 32'd2);
        if (pop_addr.size() >= 2) begin
            check("k_pop0", pop_addr[0], 32'h100);
            check("k_pop1", pop_addr[1], 32'h200);
        end

        // Asynchronous reset with two entries queued.
        ready_en = 1'b0;
        apply_reset();
        repeat (4) step();
        check("r_pre_valid", inst_valid_o, 32'd1);
        apply_reset();
        step();
        check("r_c1_req", mem_req_o, 32'd1);
        check("r_c1_addr", mem_addr_o, 32'h0);
        ready_en = 1'b1;
        step();
        step();
        check("r_c3_iaddr", inst_addr_o, 32'h0);
        check("r_c3_inst", inst_o, word_of(32'h0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
